// File: rtl/accu_uart_tx.sv
// Sends a captured 16-bit accumulator as two 8N1 UART bytes (low first); TX falls one enabled cycle after acceptance.
// Requests are taken only in IDLE (including the done cycle); store_accu is ignored while busy, everything freezes while ce=0.
module accu_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        store_accu,
  input  logic [15:0] DATA_IN,
  output logic        TX,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_nxt;
  logic [15:0] bit_timer, bit_timer_nxt;
  logic [15:0] shadow, shadow_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [2:0]  idx_inc;
  logic        byte_sel, byte_sel_nxt;
  logic        tx_nxt, done_nxt;
  logic [7:0]  cur_byte;
  logic        bit_end;

  assign cur_byte = byte_sel ? shadow[15:8] : shadow[7:0];
  assign bit_end  = (bit_timer == BIT_LAST);
  assign idx_inc  = bit_idx + 3'd1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_timer <= 16'd0;
      shadow    <= 16'h0000;
      bit_idx   <= 3'd0;
      byte_sel  <= 1'b0;
      TX        <= 1'b1;
      done      <= 1'b0;
    end else if (ce) begin
      state     <= state_nxt;
      bit_timer <= bit_timer_nxt;
      shadow    <= shadow_nxt;
      bit_idx   <= bit_idx_nxt;
      byte_sel  <= byte_sel_nxt;
      TX        <= tx_nxt;
      done      <= done_nxt;
    end
  end

  // TX is registered: each branch loads the level of the bit period it enters.
  always_comb begin
    state_nxt     = state;
    bit_timer_nxt = bit_timer + 16'd1;
    shadow_nxt    = shadow;
    bit_idx_nxt   = bit_idx;
    byte_sel_nxt  = byte_sel;
    tx_nxt        = TX;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        bit_timer_nxt = 16'd0;
        if (store_accu) begin
          shadow_nxt   = DATA_IN;
          byte_sel_nxt = 1'b0;
          state_nxt    = START;
          tx_nxt       = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          bit_timer_nxt = 16'd0;
          bit_idx_nxt   = 3'd0;
          state_nxt     = DATA;
          tx_nxt        = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_timer_nxt = 16'd0;
          bit_idx_nxt   = idx_inc;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            tx_nxt = cur_byte[idx_inc];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_timer_nxt = 16'd0;
          if (!byte_sel) begin
            // high byte follows immediately, no idle bit between bytes
            byte_sel_nxt = 1'b1;
            state_nxt    = START;
            tx_nxt       = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
